// File: rtl/apb_req_master_pkg.sv
// ---------------------------------------------------------------------------
// apb_req_master_pkg
// Shared types for the core-to-APB request master.
//   apb_state_e : transfer phase of the master FSM (IDLE/SETUP/ACCESS)
//   apb_resp_t  : response payload returned to the core (read data + error)
// The response struct carries APB_DATA_W bits of read data. The top casts
// its APB_DATA_WIDTH bus into and out of this width.
// ---------------------------------------------------------------------------
package apb_req_master_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_resp_t;

endpackage

// File: rtl/apb_req_master_if.sv
// ---------------------------------------------------------------------------
// apb_req_master_if
// Bundles the core-side request/response handshake and the APB3 initiator
// signals of apb_req_master.
//   master modport : the request master itself (drives gnt/rvalid/APB outputs)
//   slave modport  : the environment (core requester + APB node)
// Core side : req_i, gnt_o, we_i, addr_i, wdata_i, rvalid_o, rdata_o, err_o
// APB side  : paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
//             prdata_i, pready_i, pslverr_i
// ---------------------------------------------------------------------------
interface apb_req_master_if
    import apb_req_master_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
) ();

    // core side
    logic              req_i;
    logic              gnt_o;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;

    // APB side
    logic [ADDR_W-1:0] paddr_o;
    logic [DATA_W-1:0] pwdata_o;
    logic              pwrite_o;
    logic              psel_o;
    logic              penable_o;
    logic [DATA_W-1:0] prdata_i;
    logic              pready_i;
    logic              pslverr_i;

    modport master (
        input  req_i, we_i, addr_i, wdata_i, prdata_i, pready_i, pslverr_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
               paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );

    modport slave (
        output req_i, we_i, addr_i, wdata_i, prdata_i, pready_i, pslverr_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
               paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );

endinterface

// File: rtl/apb_req_master_timeout_cnt.sv
// ---------------------------------------------------------------------------
// apb_timeout_cnt
// Saturating wait-state counter used to bound the ACCESS phase.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset
//   clear   : zero the counter (start of a new transfer)
//   enable  : count one wait cycle
//   expire  : count has reached TIMEOUT_CYCLES-1 (this wait cycle is the
//             last one allowed); tied low when TIMEOUT_CYCLES == 0
// ---------------------------------------------------------------------------
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    // A zero-cycle timeout still needs a legal 1-bit register.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;

    // Wait-cycle counter: clear wins over enable, holds at CNT_MAX.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_expire
            assign expire = (count_r == CNT_LAST);
        end else begin : g_no_expire
            assign expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/apb_req_master.sv
// ---------------------------------------------------------------------------
// apb_req_master
// Converts a core-side req/gnt/rvalid request into APB3 SETUP/ACCESS
// transfers. A programmable PREADY timeout terminates an ACCESS phase that a
// hung peripheral never completes, returning an error response instead.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : apb_req_master_if.master (core handshake + APB initiator signals)
// gnt_o is combinational (high in IDLE). All other outputs are registered.
// ---------------------------------------------------------------------------
module apb_req_master
    import apb_req_master_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = APB_ADDR_W,
    parameter int APB_DATA_WIDTH = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    apb_req_master_if.master bus
);

    apb_state_e state_r;
    apb_state_e state_s;

    logic [APB_ADDR_WIDTH-1:0] paddr_r;
    logic [APB_ADDR_WIDTH-1:0] paddr_s;
    logic [APB_DATA_WIDTH-1:0] pwdata_r;
    logic [APB_DATA_WIDTH-1:0] pwdata_s;
    logic                      pwrite_r;
    logic                      pwrite_s;
    logic                      psel_r;
    logic                      psel_s;
    logic                      penable_r;
    logic                      penable_s;
    logic                      rvalid_r;
    logic                      rvalid_s;
    apb_resp_t                 resp_r;
    apb_resp_t                 resp_s;

    logic cnt_clear_s;
    logic cnt_enable_s;
    logic cnt_expire_s;

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear  (cnt_clear_s),
        .enable (cnt_enable_s),
        .expire (cnt_expire_s)
    );

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_s      = state_r;
        paddr_s      = paddr_r;
        pwdata_s     = pwdata_r;
        pwrite_s     = pwrite_r;
        rvalid_s     = 1'b0;
        resp_s       = resp_r;
        resp_s.err   = 1'b0;
        cnt_clear_s  = 1'b0;
        cnt_enable_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.req_i) begin
                    // The APB bus only addresses whole words.
                    state_s     = SETUP;
                    paddr_s     = {bus.addr_i[APB_ADDR_WIDTH-1:2], 2'b00};
                    pwdata_s    = bus.wdata_i;
                    pwrite_s    = bus.we_i;
                    cnt_clear_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end

            SETUP: begin
                state_s = ACCESS;
            end

            ACCESS: begin
                cnt_enable_s = ~bus.pready_i;
                // PREADY on the last allowed cycle still counts as a normal
                // completion, so it is tested before the timeout.
                if (bus.pready_i) begin
                    state_s      = IDLE;
                    rvalid_s     = 1'b1;
                    resp_s.err   = bus.pslverr_i;
                    if (pwrite_r) begin
                        resp_s.rdata = {APB_DATA_W{1'b0}};
                    end else begin
                        resp_s.rdata = APB_DATA_W'(bus.prdata_i);
                    end
                end else if (cnt_expire_s) begin
                    state_s      = IDLE;
                    rvalid_s     = 1'b1;
                    resp_s.err   = 1'b1;
                    resp_s.rdata = {APB_DATA_W{1'b0}};
                end else begin
                    state_s = ACCESS;
                end
            end

            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // APB strobes follow the phase the FSM is entering, so the registered
    // copies line up with the registered state.
    always_comb begin
        psel_s    = 1'b0;
        penable_s = 1'b0;
        if (state_s != IDLE) begin
            psel_s    = 1'b1;
            penable_s = (state_s == ACCESS);
        end else begin
            psel_s    = 1'b0;
            penable_s = 1'b0;
        end
    end

    // State and output registers; reset drops any transfer in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            paddr_r   <= {APB_ADDR_WIDTH{1'b0}};
            pwdata_r  <= {APB_DATA_WIDTH{1'b0}};
            pwrite_r  <= 1'b0;
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            rvalid_r  <= 1'b0;
            resp_r    <= '{rdata: {APB_DATA_W{1'b0}}, err: 1'b0};
        end else begin
            state_r   <= state_s;
            paddr_r   <= paddr_s;
            pwdata_r  <= pwdata_s;
            pwrite_r  <= pwrite_s;
            psel_r    <= psel_s;
            penable_r <= penable_s;
            rvalid_r  <= rvalid_s;
            resp_r    <= resp_s;
        end
    end

    assign bus.gnt_o     = (state_r == IDLE);
    assign bus.rvalid_o  = rvalid_r;
    assign bus.rdata_o   = APB_DATA_WIDTH'(resp_r.rdata);
    assign bus.err_o     = resp_r.err;
    assign bus.paddr_o   = paddr_r;
    assign bus.pwdata_o  = pwdata_r;
    assign bus.pwrite_o  = pwrite_r;
    assign bus.psel_o    = psel_r;
    assign bus.penable_o = penable_r;

endmodule
